uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (frame shape, line levels, FSM state
// encoding, parity helper). Used by uart_tx and intended for the receiver.
// Optional build macro: UART_TX_BREAK_EN adds the BREAK state encoding.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int FRAME_BITS     = 11;
  localparam logic IDLE_LEVEL   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    STOP,
    BREAK
`else
    STOP
`endif
  } uartState_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic evenParity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: 4-bit sample counter; BitEnd marks the last sample of
// every OVERSAMPLE-cycle bit period. Held at zero while Enable is low.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       SampleClk,
  input  logic       Reset,
  input  logic       Enable,
  output logic [3:0] SampleCnt,
  output logic       BitEnd
);

  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

  // Depends only on the register, so the FSM may use it to build Enable.
  assign BitEnd = (SampleCnt == LAST_CNT);

  // Count samples within a bit period, wrapping at the period boundary.
  always_ff @(posedge SampleClk or negedge Reset) begin
    if (!Reset)
      SampleCnt <= '0;
    else if (!Enable || BitEnd)
      SampleCnt <= '0;
    else
      SampleCnt <= SampleCnt + 4'd1;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter; frame = start, 8 data bits
// LSB first, even parity, STOP_BITS stop bits. All outputs registered
// except TxReady.
// Optional build macro: UART_TX_BREAK_EN adds TxBreak and the BREAK state.
//
// state  | meaning
// IDLE   | line high, ready for a byte (or a break request)
// START  | start bit, line low
// DATA   | data bits, shift register LSB on the line
// PARITY | even-parity bit
// STOP   | stop bit(s), TxDone on the very last cycle
// BREAK  | line held low while TxBreak, then one high bit period
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       SampleClk,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxValid,
`ifdef UART_TX_BREAK_EN
  input  logic       TxBreak,
`endif
  output logic       TxReady,
  output logic       SerialOut,
  output logic       TxBusy,
  output logic       TxDone
);

  if (DATA_BITS != 8 || OVERSAMPLE < 2 || OVERSAMPLE > 16 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : gBadParam
    $error("uart_tx: illegal parameter combination");
  end

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0] DONE_CNT  = 4'(OVERSAMPLE - 2);

  uartState_e state;
  logic [7:0] shiftReg;
  logic       parityBit;
  logic [3:0] bitIdx;
  logic [3:0] sampleCnt;
  logic       bitEnd;
  logic       timerEn;

  assign TxReady = (state == IDLE) && Reset;

`ifdef UART_TX_BREAK_EN
  logic breakHold;
  logic breakMinMet;
  logic breakRestart;

  // Minimum break length is reached on the edge ending the 11th bit period.
  assign breakMinMet  = (bitIdx == 4'(FRAME_BITS)) ||
                        ((bitIdx == 4'(FRAME_BITS - 1)) && bitEnd);
  // Restarting the timer on release makes the trailing high period a full bit.
  assign breakRestart = (state == BREAK) && !breakHold && !TxBreak && breakMinMet;
  assign timerEn      = (state != IDLE) && !breakRestart;
`else
  assign timerEn      = (state != IDLE);
`endif

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) uBitTimer (
    .SampleClk (SampleClk),
    .Reset     (Reset),
    .Enable    (timerEn),
    .SampleCnt (sampleCnt),
    .BitEnd    (bitEnd)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge SampleClk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      SerialOut <= IDLE_LEVEL;
      TxBusy    <= 1'b0;
      TxDone    <= 1'b0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      bitIdx    <= '0;
`ifdef UART_TX_BREAK_EN
      breakHold <= 1'b0;
`endif
    end else begin
      TxDone <= 1'b0;
      case (state)
        IDLE: begin
          SerialOut <= IDLE_LEVEL;
          TxBusy    <= 1'b0;
          bitIdx    <= '0;
`ifdef UART_TX_BREAK_EN
          if (TxBreak) begin
            state     <= BREAK;
            SerialOut <= 1'b0;
            TxBusy    <= 1'b1;
            breakHold <= 1'b0;
          end else
`endif
          if (TxValid && TxReady) begin
            shiftReg  <= TxData;
            parityBit <= evenParity(TxData);
            state     <= START;
            SerialOut <= 1'b0;
            TxBusy    <= 1'b1;
          end
        end
        START: begin
          if (bitEnd) begin
            state     <= DATA;
            SerialOut <= shiftReg[0];
            bitIdx    <= '0;
          end
        end
        DATA: begin
          if (bitEnd) begin
            if (bitIdx == DATA_LAST) begin
              state     <= PARITY;
              SerialOut <= parityBit;
              bitIdx    <= '0;
            end else begin
              shiftReg  <= {1'b0, shiftReg[7:1]};
              SerialOut <= shiftReg[1];
              bitIdx    <= bitIdx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bitEnd) begin
            state     <= STOP;
            SerialOut <= 1'b1;
            bitIdx    <= '0;
          end
        end
        STOP: begin
          if (bitIdx == STOP_LAST && sampleCnt == DONE_CNT)
            TxDone <= 1'b1;
          if (bitEnd) begin
            if (bitIdx == STOP_LAST) begin
              state  <= IDLE;
              TxBusy <= 1'b0;
            end else begin
              bitIdx <= bitIdx + 4'd1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!breakHold) begin
            if (bitEnd && bitIdx != 4'(FRAME_BITS))
              bitIdx <= bitIdx + 4'd1;
            if (!TxBreak && breakMinMet) begin
              breakHold <= 1'b1;
              SerialOut <= 1'b1;
            end
          end else if (bitEnd) begin
            state     <= IDLE;
            TxBusy    <= 1'b0;
            breakHold <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          SerialOut <= IDLE_LEVEL;
          TxBusy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Expected frames are queued when
// a byte is offered; a line monitor decodes each frame and checks it when
// TxDone appears. Build with UART_TX_BREAK_EN to also exercise TxBreak.
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } expFrame_t;

  logic       SampleClk = 1'b0;
  logic       Reset;
  logic [7:0] TxData;
  logic       TxValid;
`ifdef UART_TX_BREAK_EN
  logic       TxBreak;
`endif
  logic       TxReady;
  logic       SerialOut;
  logic       TxBusy;
  logic       TxDone;

  int nCompared   = 0;
  int nMismatched = 0;
  expFrame_t expQ[$];
  logic monEnable = 1'b1;

  always #5 SampleClk = ~SampleClk;

  uart_tx dut (
    .SampleClk (SampleClk),
    .Reset     (Reset),
    .TxData    (TxData),
    .TxValid   (TxValid),
`ifdef UART_TX_BREAK_EN
    .TxBreak   (TxBreak),
`endif
    .TxReady   (TxReady),
    .SerialOut (SerialOut),
    .TxBusy    (TxBusy),
    .TxDone    (TxDone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: decodes a frame from the first low sample, compares on TxDone.
  initial begin : monitor
    int cyc;
    int bitNo;
    int pos;
    int glitches;
    logic active;
    logic [10:0] bits;
    expFrame_t e;
    active = 1'b0;
    cyc = 0;
    glitches = 0;
    bits = '0;
    forever begin
      @(negedge SampleClk);
      if (!Reset || !monEnable) begin
        active = 1'b0;
      end else if (!active) begin
        if (TxDone) check("spurious_txdone", TxDone, 1'b0);
        if (SerialOut == 1'b0) begin
          active = 1'b1;
          cyc = 1;
          glitches = 0;
          bits = '0;
          bits[0] = SerialOut;
        end
      end else begin
        cyc++;
        bitNo = (cyc - 1) / 16;
        pos = (cyc - 1) % 16;
        if (bitNo < 11) begin
          if (pos == 0) bits[bitNo] = SerialOut;
          else if (SerialOut !== bits[bitNo]) glitches++;
        end
        if (TxDone) begin
          active = 1'b0;
          check("frame_expected", expQ.size() > 0, 1'b1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("done_cycle", cyc, 176);
            check("start_bit", bits[0], 1'b0);
            check("rx_data", bits[8:1], e.data);
            check("rx_parity", bits[9], e.parity);
            check("rx_stop", bits[10], 1'b1);
            check("bit_stability", glitches, 0);
          end
        end else if (cyc > 180) begin
          active = 1'b0;
          check("txdone_timeout", cyc, 176);
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] d, input logic par, input bit holdValid);
    @(negedge SampleClk);
    check("ready_before_send", TxReady, 1'b1);
    TxData = d;
    TxValid = 1'b1;
    expQ.push_back('{d, par});
    @(posedge SampleClk);
    #1;
    if (!holdValid) TxValid = 1'b0;
    check("line_falls_on_handshake", SerialOut, 1'b0);
    check("busy_on_handshake", TxBusy, 1'b1);
    check("ready_low_after_handshake", TxReady, 1'b0);
  endtask

  task automatic trackFrame(input int expLow);
    int doneCyc = 0;
    int doneCnt = 0;
    int lowCnt = 0;
    int readyEarly = 0;
    for (int k = 1; k <= 177; k++) begin
      @(negedge SampleClk);
      if (k <= 176) begin
        if (!SerialOut) lowCnt++;
        if (TxReady) readyEarly++;
        if (TxDone) begin
          doneCnt++;
          doneCyc = k;
        end
      end else begin
        check("ready_back_cycle_177", TxReady, 1'b1);
        check("busy_clear_cycle_177", TxBusy, 1'b0);
      end
    end
    check("txdone_cycle", doneCyc, 176);
    check("txdone_pulse_count", doneCnt, 1);
    check("low_cycles", lowCnt, expLow);
    check("ready_low_during_frame", readyEarly, 0);
  endtask

  initial begin : stimulus
    int bad;
    int firstDone;
    int secondDone;
    int doneSeen;
    Reset = 1'b0;
    TxValid = 1'b0;
    TxData = 8'h00;
`ifdef UART_TX_BREAK_EN
    TxBreak = 1'b0;
`endif
    #20;
    check("reset_line", SerialOut, 1'b1);
    check("reset_busy", TxBusy, 1'b0);
    check("reset_ready", TxReady, 1'b0);
    check("reset_done", TxDone, 1'b0);
    #30;
    Reset = 1'b1;

    bad = 0;
    repeat (500) begin
      @(negedge SampleClk);
      if (SerialOut !== 1'b1 || TxBusy !== 1'b0 || TxReady !== 1'b1 || TxDone !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);

    sendByte(8'hA5, 1'b0, 0);
    trackFrame(96);
    sendByte(8'h07, 1'b1, 0);
    trackFrame(96);
    sendByte(8'h00, 1'b0, 0);
    trackFrame(160);

    // Back-to-back with TxValid held; TxData changes mid-frame.
    sendByte(8'h3C, 1'b0, 1);
    firstDone = 0;
    secondDone = 0;
    for (int k = 1; k <= 356; k++) begin
      @(negedge SampleClk);
      if (k == 50) begin
        TxData = 8'hC3;
        expQ.push_back('{8'hC3, 1'b0});
      end
      if (TxDone) begin
        if (firstDone == 0) firstDone = k;
        else secondDone = k;
      end
      if (k == 177) begin
        check("b2b_idle_line", SerialOut, 1'b1);
        check("b2b_idle_ready", TxReady, 1'b1);
      end
      if (k == 178) begin
        check("b2b_second_start", SerialOut, 1'b0);
        TxValid = 1'b0;
      end
    end
    check("b2b_first_done", firstDone, 176);
    check("b2b_second_done", secondDone, 353);

    // Reset in the middle of a frame (cycle 60 is data bit 2 of 0x81, a zero).
    sendByte(8'h81, 1'b0, 0);
    repeat (60) @(negedge SampleClk);
    check("line_low_before_reset", SerialOut, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    check("midframe_reset_line", SerialOut, 1'b1);
    check("midframe_reset_busy", TxBusy, 1'b0);
    check("midframe_reset_ready", TxReady, 1'b0);
    expQ.delete();
    repeat (5) @(negedge SampleClk);
    Reset = 1'b1;
    doneSeen = 0;
    repeat (200) begin
      @(negedge SampleClk);
      if (TxDone) doneSeen++;
    end
    check("no_done_after_abort", doneSeen, 0);

    sendByte(8'h5A, 1'b0, 0);
    trackFrame(96);

`ifdef UART_TX_BREAK_EN
    begin
      int lowCnt;
      int highCnt;
      int readyAt;
      monEnable = 1'b0;
      @(negedge SampleClk);
      TxBreak = 1'b1;
      TxValid = 1'b1;
      TxData = 8'hFF;
      @(posedge SampleClk);
      #1;
      TxValid = 1'b0;
      check("break_line_low", SerialOut, 1'b0);
      check("break_busy", TxBusy, 1'b1);
      check("break_ready_low", TxReady, 1'b0);
      lowCnt = 0;
      highCnt = 0;
      readyAt = 0;
      for (int k = 1; k <= 260; k++) begin
        @(negedge SampleClk);
        if (readyAt == 0) begin
          if (TxReady) readyAt = k;
          else if (!SerialOut) lowCnt++;
          else highCnt++;
        end
        if (k == 200) TxBreak = 1'b0;
      end
      check("break_low_cycles", lowCnt, 200);
      check("break_release_high", highCnt, 16);
      check("break_ready_cycle", readyAt, 217);
      check("break_no_frame", TxBusy, 1'b0);
      monEnable = 1'b1;
    end
`endif

    repeat (20) @(negedge SampleClk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
